// File: rtl/reg_dest_if.sv
// Handshake bundle between the control unit / instruction register and the
// destination-register unit of the multicycle MIPS datapath.
interface reg_dest_if #(
    parameter int REG_ADDR_W = 5
);
    logic [2:0]            seletor_regdest;
    logic [REG_ADDR_W-1:0] rt;
    logic [REG_ADDR_W-1:0] rd;
    logic                  dest_capture;
    logic                  wb_valid;
    logic                  flush;
    logic [REG_ADDR_W-1:0] query_a;
    logic [REG_ADDR_W-1:0] query_b;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] dest_out;
    logic                  dest_valid;
    logic                  sel_err;
    logic                  overrun;
    logic                  hazard;

    modport master (
        output seletor_regdest, rt, rd, dest_capture, wb_valid, flush, query_a, query_b,
        input  reg_write, dest_out, dest_valid, sel_err, overrun, hazard
    );

    modport slave (
        input  seletor_regdest, rt, rd, dest_capture, wb_valid, flush, query_a, query_b,
        output reg_write, dest_out, dest_valid, sel_err, overrun, hazard
    );
endinterface

// File: rtl/reg_dest_ctrl.sv
// Destination-register unit: selects, holds and commits the write register.
// Optional macro REG_DEST_HAZARD_EN enables the RAW hazard compare.
module reg_dest_ctrl #(
    parameter int REG_ADDR_W = 5,
    parameter int SP_REG     = 29,
    parameter int FP_REG     = 30,
    parameter int RA_REG     = 31
) (
    input  logic         clk,
    input  logic         reset_n,
    reg_dest_if.slave    bus
);
    typedef enum logic {IDLE, HELD} state_t;

    state_t                state;
    logic [REG_ADDR_W-1:0] dest_q;
    logic [REG_ADDR_W-1:0] next_dest;
    logic [REG_ADDR_W-1:0] sel_dest;
    logic                  sel_illegal;
    logic                  committing;
    logic                  load_pending;
    logic                  reg_write_q;
    logic                  sel_err_q;
    logic                  overrun_q;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        sel_dest    = '0;
        sel_illegal = 1'b0;
        case (bus.seletor_regdest)
            3'b000:  sel_dest = bus.rt;
            3'b001:  sel_dest = bus.rd;
            3'b010:  sel_dest = SP_REG[REG_ADDR_W-1:0];
            3'b011:  sel_dest = FP_REG[REG_ADDR_W-1:0];
            3'b100:  sel_dest = RA_REG[REG_ADDR_W-1:0];
            default: sel_illegal = 1'b1;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= IDLE;
            dest_q       <= '0;
            next_dest    <= '0;
            committing   <= 1'b0;
            load_pending <= 1'b0;
            reg_write_q  <= 1'b0;
            sel_err_q    <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            reg_write_q <= 1'b0;
            sel_err_q   <= 1'b0;
            if (bus.flush) begin
                state        <= IDLE;
                dest_q       <= '0;
                committing   <= 1'b0;
                load_pending <= 1'b0;
            end else if (committing) begin
                // Write pulse cycle: the old address is on the bus, resolve what follows it.
                committing <= 1'b0;
                if (load_pending) begin
                    dest_q       <= next_dest;
                    load_pending <= 1'b0;
                    if (bus.dest_capture)
                        overrun_q <= 1'b1;
                end else if (bus.dest_capture) begin
                    dest_q    <= sel_dest;
                    sel_err_q <= sel_illegal;
                end else begin
                    state  <= IDLE;
                    dest_q <= '0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.dest_capture) begin
                            state     <= HELD;
                            dest_q    <= sel_dest;
                            sel_err_q <= sel_illegal;
                        end
                    end
                    HELD: begin
                        if (bus.wb_valid) begin
                            committing  <= 1'b1;
                            reg_write_q <= (dest_q != '0);
                            if (bus.dest_capture) begin
                                next_dest    <= sel_dest;
                                load_pending <= 1'b1;
                                sel_err_q    <= sel_illegal;
                            end
                        end else if (bus.dest_capture) begin
                            overrun_q <= 1'b1;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

    assign bus.dest_out   = dest_q;
    assign bus.dest_valid = (state == HELD);
    assign bus.reg_write  = reg_write_q;
    assign bus.sel_err    = sel_err_q;
    assign bus.overrun    = overrun_q;

`ifdef REG_DEST_HAZARD_EN
    assign bus.hazard = (state == HELD) && (dest_q != '0) &&
                        ((bus.query_a == dest_q) || (bus.query_b == dest_q));
`else
    logic unused_query;
    assign unused_query = ^{bus.query_a, bus.query_b};
    assign bus.hazard   = 1'b0;
`endif
endmodule

// File: tb/tb_reg_dest_ctrl.sv
// Self-checking bench for reg_dest_ctrl: directed scenarios followed by
// randomized transactions against a transaction-level reference model.
module tb_reg_dest_ctrl;
    logic clk = 1'b0;
    logic reset_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    reg_dest_if #(.REG_ADDR_W(5)) bus ();

    reg_dest_ctrl #(.REG_ADDR_W(5), .SP_REG(29), .FP_REG(30), .RA_REG(31)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    // Expected observable state, advanced one transaction step at a time.
    bit exp_valid, exp_rw, exp_err, exp_ovr;
    int exp_dest;

    function automatic int ref_sel(input int sel, input int t, input int d);
        case (sel)
            0:       return t;
            1:       return d;
            2:       return 29;
            3:       return 30;
            4:       return 31;
            default: return 0;
        endcase
    endfunction

    function automatic bit exp_hazard();
`ifdef REG_DEST_HAZARD_EN
        return exp_valid && exp_dest != 0 &&
               (int'(bus.query_a) == exp_dest || int'(bus.query_b) == exp_dest);
`else
        return 1'b0;
`endif
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".dest_valid"}, 32'(bus.dest_valid), 32'(exp_valid));
        chk({tag, ".dest_out"},   32'(bus.dest_out),   32'(exp_dest));
        chk({tag, ".reg_write"},  32'(bus.reg_write),  32'(exp_rw));
        chk({tag, ".sel_err"},    32'(bus.sel_err),    32'(exp_err));
        chk({tag, ".overrun"},    32'(bus.overrun),    32'(exp_ovr));
        chk({tag, ".hazard"},     32'(bus.hazard),     32'(exp_hazard()));
    endtask

    task automatic cycle(input bit rst, input bit cap, input bit wb, input bit fl,
                         input int sel, input int t, input int d);
        reset_n             = ~rst;
        bus.dest_capture    = cap;
        bus.wb_valid        = wb;
        bus.flush           = fl;
        bus.seletor_regdest = 3'(sel);
        bus.rt              = 5'(t);
        bus.rd              = 5'(d);
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic rand_query();
        bus.query_a = ($urandom_range(0, 2) == 0) ? 5'(exp_dest) : 5'($urandom);
        bus.query_b = ($urandom_range(0, 2) == 0) ? 5'(exp_dest) : 5'($urandom);
        #1;
    endtask

    task automatic clear_exp();
        exp_valid = 0; exp_dest = 0; exp_rw = 0; exp_err = 0;
    endtask

    initial begin
        int sel, sel2, t, d, t2, d2, dst, gap, pick;
        bus.query_a = '0;
        bus.query_b = '0;
        clear_exp();
        exp_ovr = 0;

        // 1: reset holds everything low even with capture / wb_valid active
        cycle(1, 1, 0, 0, 1, 3, 9);  check_all("rst0");
        cycle(1, 1, 1, 0, 4, 3, 9);  check_all("rst1");

        // 2: rd capture, hold three cycles, commit, clear
        cycle(0, 1, 0, 0, 1, 2, 9);
        exp_valid = 1; exp_dest = 9; check_all("t2.cap");
        repeat (3) begin idle(); check_all("t2.hold"); end
        cycle(0, 0, 1, 0, 0, 0, 0);
        exp_rw = 1; check_all("t2.wb");
        idle(); clear_exp(); check_all("t2.done");

        // 3: $ra then back-to-back commit with rt=4 capture
        cycle(0, 1, 0, 0, 4, 0, 0);
        exp_valid = 1; exp_dest = 31; check_all("t3.cap");
        cycle(0, 1, 1, 0, 0, 4, 0);
        exp_rw = 1; check_all("t3.b2b");
        idle(); exp_rw = 0; exp_dest = 4; check_all("t3.load");
        cycle(0, 0, 1, 0, 0, 0, 0); exp_rw = 1; check_all("t3.wb");
        idle(); clear_exp(); check_all("t3.done");

        // 4: illegal selector latches 0, no write on commit
        cycle(0, 1, 0, 0, 6, 7, 8);
        exp_valid = 1; exp_dest = 0; exp_err = 1; check_all("t4.cap");
        idle(); exp_err = 0; check_all("t4.hold");
        cycle(0, 0, 1, 0, 0, 0, 0); check_all("t4.wb");
        idle(); clear_exp(); check_all("t4.done");

        // 5: $sp capture, hazard queries, flush
        cycle(0, 1, 0, 0, 2, 0, 0);
        exp_valid = 1; exp_dest = 29;
        bus.query_a = 5'd29; bus.query_b = 5'd0; #1;
`ifdef REG_DEST_HAZARD_EN
        chk("t5.hazard_hit", 32'(bus.hazard), 32'd1);
`else
        chk("t5.hazard_hit", 32'(bus.hazard), 32'd0);
`endif
        bus.query_a = 5'd0; #1;
        chk("t5.hazard_miss", 32'(bus.hazard), 32'd0);
        check_all("t5.held");
        cycle(0, 1, 1, 1, 1, 0, 5);
        clear_exp(); check_all("t5.flush");
        idle(); check_all("t5.after");

        // 6: overrun is sticky until reset
        cycle(0, 1, 0, 0, 1, 0, 7);
        exp_valid = 1; exp_dest = 7; check_all("t6.cap");
        cycle(0, 1, 0, 0, 0, 3, 0);
        exp_ovr = 1; check_all("t6.ovr");
        idle(); check_all("t6.hold");
        cycle(0, 0, 1, 0, 0, 0, 0); exp_rw = 1; check_all("t6.wb");
        idle(); clear_exp(); check_all("t6.done");
        cycle(1, 0, 0, 0, 0, 0, 0); exp_ovr = 0; check_all("t6.rst");

        // Randomized transactions
        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 7); t = $urandom_range(0, 31); d = $urandom_range(0, 31);
            dst = ref_sel(sel, t, d);
            if ($urandom_range(0, 3) == 0) begin
                cycle(0, 0, 1, 0, 0, 0, 0); rand_query(); check_all("r.idle_wb");
            end
            cycle(0, 1, 0, 0, sel, t, d);
            exp_valid = 1; exp_dest = dst; exp_err = (sel > 4); exp_rw = 0;
            rand_query(); check_all("r.cap");
            exp_err = 0;
            gap = $urandom_range(0, 3);
            for (int g = 0; g < gap; g++) begin
                if ($urandom_range(0, 5) == 0) begin
                    cycle(0, 1, 0, 0, $urandom_range(0, 4), $urandom_range(0, 31), $urandom_range(0, 31));
                    exp_ovr = 1;
                end else begin
                    idle();
                end
                rand_query(); check_all("r.hold");
            end
            pick = $urandom_range(0, 3);
            if (pick == 0) begin
                cycle(0, $urandom_range(0, 1), $urandom_range(0, 1), 1, 1, 0, 0);
                clear_exp(); rand_query(); check_all("r.flush");
            end else if (pick == 3) begin
                sel2 = $urandom_range(0, 7); t2 = $urandom_range(0, 31); d2 = $urandom_range(0, 31);
                cycle(0, 1, 1, 0, sel2, t2, d2);
                exp_rw = (dst != 0); exp_err = (sel2 > 4);
                rand_query(); check_all("r.b2b");
                idle();
                exp_rw = 0; exp_err = 0; exp_dest = ref_sel(sel2, t2, d2);
                rand_query(); check_all("r.b2b_load");
                cycle(0, 0, 0, 1, 0, 0, 0);
                clear_exp(); rand_query(); check_all("r.b2b_flush");
            end else begin
                cycle(0, 0, 1, 0, 0, 0, 0);
                exp_rw = (dst != 0);
                rand_query(); check_all("r.wb");
                idle(); clear_exp(); rand_query(); check_all("r.done");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
